// File: rtl/change_dispense_controller_if.sv
// ----------------------------------------------------------------------------
// change_dispense_controller_if
//   Bundles the change-request handshake, the hopper drive/acknowledge pair
//   and the per-transaction result signals that connect the vending FSM and
//   the coin hoppers to change_dispense_controller.
//
//   req_valid / req_ready / req_amount : change request handshake (cents)
//   hopper_q / hopper_d / hopper_n     : hopper eject drives (one at a time)
//   hopper_ack                         : hopper confirms one coin ejected
//   done / short_amt / err_jam         : end-of-transaction result
//
//   master : the vending FSM / hopper side
//   slave  : the controller
// ----------------------------------------------------------------------------
interface change_dispense_controller_if #(
    parameter int AMT_W = 9
);
    logic             req_valid;
    logic             req_ready;
    logic [AMT_W-1:0] req_amount;
    logic             hopper_q;
    logic             hopper_d;
    logic             hopper_n;
    logic             hopper_ack;
    logic             done;
    logic [AMT_W-1:0] short_amt;
    logic             err_jam;

    modport master (
        output req_valid,
        output req_amount,
        output hopper_ack,
        input  req_ready,
        input  hopper_q,
        input  hopper_d,
        input  hopper_n,
        input  done,
        input  short_amt,
        input  err_jam
    );

    modport slave (
        input  req_valid,
        input  req_amount,
        input  hopper_ack,
        output req_ready,
        output hopper_q,
        output hopper_d,
        output hopper_n,
        output done,
        output short_amt,
        output err_jam
    );
endinterface

// File: rtl/change_dispense_controller.sv
// ----------------------------------------------------------------------------
// change_dispense_controller
//   Pays out one change request greedily (quarters, then dimes, then nickels)
//   from tracked coin-tube inventories. One hopper is pulsed at a time and the
//   controller waits for its eject acknowledge before choosing the next coin.
//   A missing acknowledge ends the transaction as a jam. The unpaid remainder
//   (including the sub-nickel part) is reported as short_amt with done.
//
// Ports
//   clk                  system clock, rising edge
//   rst                  synchronous, active-low reset
//   bus                  request / hopper / result interface (slave side)
//   refill_q/d/n         one coin routed into the matching tube this cycle
//   quart/dim/nick       coins of each type paid in the current/last request
//   tube_q/d/n           current tube inventories
// ----------------------------------------------------------------------------
module change_dispense_controller #(
    parameter int AMT_W       = 9,
    parameter int CNT_W       = 9,
    parameter int TUBE_INIT   = 4,
    parameter int PULSE_CYC   = 2,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    change_dispense_controller_if.slave bus,
    input  logic                       refill_q,
    input  logic                       refill_d,
    input  logic                       refill_n,
    output logic [CNT_W-1:0]           quart,
    output logic [CNT_W-1:0]           dim,
    output logic [CNT_W-1:0]           nick,
    output logic [CNT_W-1:0]           tube_q,
    output logic [CNT_W-1:0]           tube_d,
    output logic [CNT_W-1:0]           tube_n
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SELECT   = 3'd1,
        PULSE    = 3'd2,
        WAIT_ACK = 3'd3,
        FINISH   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        COIN_Q = 2'd0,
        COIN_D = 2'd1,
        COIN_N = 2'd2
    } coin_t;

    // Counters count down/up to PULSE_CYC-1 and ACK_TIMEOUT-1 respectively.
    localparam int PW = (PULSE_CYC   > 1) ? $clog2(PULSE_CYC)   : 1;
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TUBE_MAX = '1;

    state_t           state;
    state_t           state_nxt;
    coin_t            coin;
    logic [AMT_W-1:0] rem;
    logic [2:0]       odd;
    logic [PW-1:0]    pulse_cnt;
    logic [TW-1:0]    wait_cnt;
    logic [AMT_W-1:0] short_hold;
    logic             jam_flag;

    logic             accept;
    logic             pick_q;
    logic             pick_d;
    logic             pick_n;
    logic             pick_any;
    logic             pulse_last;
    logic             ack_taken;
    logic             timeout;
    logic [AMT_W-1:0] amt_mod5;
    logic             take_q;
    logic             take_d;
    logic             take_n;

    function automatic logic [AMT_W-1:0] coin_value(input coin_t c);
        case (c)
            COIN_Q:  coin_value = AMT_W'(25);
            COIN_D:  coin_value = AMT_W'(10);
            default: coin_value = AMT_W'(5);
        endcase
    endfunction

    // Refill saturates at full scale; a refill and a payout in the same cycle cancel.
    function automatic logic [CNT_W-1:0] tube_next(input logic [CNT_W-1:0] cur,
                                                   input logic             inc,
                                                   input logic             dec);
        if (inc && !dec)
            tube_next = (cur == TUBE_MAX) ? cur : cur + CNT_W'(1);
        else if (dec && !inc)
            tube_next = cur - CNT_W'(1);
        else
            tube_next = cur;
    endfunction

    assign accept     = bus.req_valid && (state == IDLE);
    assign amt_mod5   = bus.req_amount % AMT_W'(5);
    assign pick_q     = (rem >= AMT_W'(25)) && (tube_q != '0);
    assign pick_d     = (rem >= AMT_W'(10)) && (tube_d != '0);
    assign pick_n     = (rem >= AMT_W'(5))  && (tube_n != '0);
    assign pick_any   = pick_q || pick_d || pick_n;
    assign pulse_last = (pulse_cnt == '0);
    assign ack_taken  = (state == WAIT_ACK) && bus.hopper_ack;
    assign timeout    = (state == WAIT_ACK) && !bus.hopper_ack
                        && (wait_cnt == TW'(ACK_TIMEOUT - 1));
    assign take_q     = ack_taken && (coin == COIN_Q);
    assign take_d     = ack_taken && (coin == COIN_D);
    assign take_n     = ack_taken && (coin == COIN_N);

    assign bus.short_amt = short_hold;
    assign bus.err_jam   = jam_flag;

    // State register
    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (accept) state_nxt = SELECT;
            SELECT:   state_nxt = pick_any ? PULSE : FINISH;
            PULSE:    if (pulse_last) state_nxt = WAIT_ACK;
            WAIT_ACK: begin
                if (bus.hopper_ack)
                    state_nxt = SELECT;
                else if (timeout)
                    state_nxt = FINISH;
            end
            FINISH:   state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the current state; the hopper drive is never
    // registered so a reset drops it at the same edge.
    always_comb begin
        bus.req_ready = 1'b0;
        bus.hopper_q  = 1'b0;
        bus.hopper_d  = 1'b0;
        bus.hopper_n  = 1'b0;
        bus.done      = 1'b0;
        unique case (state)
            IDLE:   bus.req_ready = 1'b1;
            PULSE: begin
                bus.hopper_q = (coin == COIN_Q);
                bus.hopper_d = (coin == COIN_D);
                bus.hopper_n = (coin == COIN_N);
            end
            FINISH: bus.done = 1'b1;
            default: ;
        endcase
    end

    // Transaction datapath: remainder, coin choice, timers, results
    always_ff @(posedge clk) begin
        if (!rst) begin
            rem        <= '0;
            odd        <= '0;
            coin       <= COIN_Q;
            pulse_cnt  <= '0;
            wait_cnt   <= '0;
            quart      <= '0;
            dim        <= '0;
            nick       <= '0;
            short_hold <= '0;
            jam_flag   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        rem      <= bus.req_amount - amt_mod5;
                        odd      <= amt_mod5[2:0];
                        quart    <= '0;
                        dim      <= '0;
                        nick     <= '0;
                        jam_flag <= 1'b0;
                    end
                end
                SELECT: begin
                    if (pick_q)
                        coin <= COIN_Q;
                    else if (pick_d)
                        coin <= COIN_D;
                    else
                        coin <= COIN_N;
                    pulse_cnt <= PW'(PULSE_CYC - 1);
                    wait_cnt  <= '0;
                    if (!pick_any)
                        short_hold <= rem + AMT_W'(odd);
                end
                PULSE: begin
                    if (!pulse_last)
                        pulse_cnt <= pulse_cnt - PW'(1);
                end
                WAIT_ACK: begin
                    if (bus.hopper_ack) begin
                        rem <= rem - coin_value(coin);
                        if (coin == COIN_Q)
                            quart <= quart + CNT_W'(1);
                        else if (coin == COIN_D)
                            dim <= dim + CNT_W'(1);
                        else
                            nick <= nick + CNT_W'(1);
                    end else if (timeout) begin
                        // Jam: remainder and tube stay as they were.
                        jam_flag   <= 1'b1;
                        short_hold <= rem + AMT_W'(odd);
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Tube inventories; refills are accepted in every state
    always_ff @(posedge clk) begin
        if (!rst) begin
            tube_q <= CNT_W'(TUBE_INIT);
            tube_d <= CNT_W'(TUBE_INIT);
            tube_n <= CNT_W'(TUBE_INIT);
        end else begin
            tube_q <= tube_next(tube_q, refill_q, take_q);
            tube_d <= tube_next(tube_d, refill_d, take_d);
            tube_n <= tube_next(tube_n, refill_n, take_n);
        end
    end

endmodule
